// File: rtl/press_classifier_if.sv
// Button-gesture bus between the input conditioner and the press classifier.
// master = conditioner side (drives the button stream), slave = classifier.
interface press_classifier_if;
    logic       cond;
    logic       rising;
    logic       falling;
    logic       short_press;
    logic       long_press;
    logic       double_press;
    logic       held;
    logic [2:0] state;

    modport master (
        output cond, rising, falling,
        input  short_press, long_press, double_press, held, state
    );

    modport slave (
        input  cond, rising, falling,
        output short_press, long_press, double_press, held, state
    );
endinterface

// File: rtl/press_classifier.sv
// Classifies conditioned button gestures into short / long / double press pulses.
//
// state  | meaning
// IDLE   | no gesture in progress
// PRESS1 | first press held, counting toward long threshold
// WAIT   | first press released, counting the double-press window
// PRESS2 | second press held, counting toward long threshold
// LONG   | long press reported, waiting for release
module press_classifier #(
    parameter int LONG_T = 8,
    parameter int DBL_T  = 6,
    parameter int CW     = 4
) (
    input  logic              clk,
    input  logic              reset,
    press_classifier_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRESS1 = 3'd1,
        WAIT   = 3'd2,
        PRESS2 = 3'd3,
        LONG   = 3'd4
    } state_t;

    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_T - 1);
    localparam logic [CW-1:0] DBL_LAST  = CW'(DBL_T - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          short_q, short_d;
    logic          long_q, long_d;
    logic          dbl_q, dbl_d;
    logic          rise_ev, fall_ev, fall_eff;

    // Simultaneous rising/falling is illegal and counts as no event.
    assign rise_ev  = bus.rising & ~bus.falling;
    assign fall_ev  = bus.falling & ~bus.rising;
    // A low level while pressed means the falling pulse was missed.
    assign fall_eff = fall_ev | ~bus.cond;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            short_q <= 1'b0;
            long_q  <= 1'b0;
            dbl_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            short_q <= short_d;
            long_q  <= long_d;
            dbl_q   <= dbl_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        short_d = 1'b0;
        long_d  = 1'b0;
        dbl_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise_ev) begin
                    state_d = PRESS1;
                    cnt_d   = '0;
                end
            end
            PRESS1: begin
                if (fall_eff) begin
                    state_d = WAIT;
                    cnt_d   = '0;
                end else if (cnt_q == LONG_LAST) begin
                    state_d = LONG;
                    long_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT: begin
                if (rise_ev) begin
                    state_d = PRESS2;
                    cnt_d   = '0;
                end else if (cnt_q == DBL_LAST) begin
                    state_d = IDLE;
                    short_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PRESS2: begin
                if (fall_eff) begin
                    state_d = IDLE;
                    dbl_d   = 1'b1;
                end else if (cnt_q == LONG_LAST) begin
                    state_d = LONG;
                    long_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LONG: begin
                if (fall_eff) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign bus.short_press  = short_q;
    assign bus.long_press   = long_q;
    assign bus.double_press = dbl_q;
    assign bus.held         = (state_q == PRESS1) || (state_q == PRESS2) || (state_q == LONG);
    assign bus.state        = state_q;
endmodule

// File: tb/tb_press_classifier.sv
// Directed bench for press_classifier (LONG_T=8, DBL_T=6, CW=4): gesture table plus corner sequences.
module tb_press_classifier;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    press_classifier_if bus ();

    press_classifier #(.LONG_T(8), .DBL_T(6), .CW(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Edge numbers are counted from the first edge after reset release; -1 means none.
    typedef struct {
        string name;
        int    r1, f1, r2, f2;
        int    n;
        int    exp_short, exp_long, exp_dbl;
        int    exp_state;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        reset       = 1'b1;
        bus.cond    = 1'b0;
        bus.rising  = 1'b0;
        bus.falling = 1'b0;
        repeat (cycles) tick();
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int first_s, first_l, first_d, cnt_s, cnt_l, cnt_d, held_bad, multi;
        logic held_exp;

        //           name          r1  f1  r2  f2   n  short long dbl state
        vecs[0] = '{"short",       10, 13, -1, -1, 30, 19,   -1,  -1,  0};
        vecs[1] = '{"long",        10, 30, -1, -1, 32, -1,   18,  -1,  0};
        vecs[2] = '{"double",      10, 12, 15, 17, 30, -1,   -1,  17,  0};
        vecs[3] = '{"dbl_edge",    10, 12, 18, 20, 30, -1,   -1,  20,  0};
        vecs[4] = '{"dbl_late",    10, 12, 19, 21, 25, 18,   -1,  -1,  2};
        vecs[5] = '{"press2_long", 10, 12, 14, 26, 30, -1,   22,  -1,  0};
        vecs[6] = '{"illegal",     10, 10, -1, -1, 20, -1,   -1,  -1,  0};

        // Reset held 3 cycles with a rising pulse in the middle
        reset       = 1'b1;
        bus.cond    = 1'b0;
        bus.rising  = 1'b0;
        bus.falling = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.rising = (i == 1);
            bus.cond   = (i >= 1);
            tick();
            check("reset_state", bus.state, 0);
            check("reset_held", bus.held, 0);
        end
        reset      = 1'b0;
        bus.rising = 1'b0;
        bus.cond   = 1'b0;
        cnt_s = 0;
        for (int e = 1; e <= 12; e++) begin
            tick();
            cnt_s += int'(bus.short_press) + int'(bus.long_press) + int'(bus.double_press);
        end
        check("reset_no_pulse", cnt_s, 0);
        check("reset_idle", bus.state, 0);

        // Gesture table
        for (int v = 0; v < 7; v++) begin
            do_reset(2);
            first_s = -1; first_l = -1; first_d = -1;
            cnt_s = 0; cnt_l = 0; cnt_d = 0; held_bad = 0; multi = 0;
            for (int e = 1; e <= vecs[v].n; e++) begin
                bus.rising  = (e == vecs[v].r1) || (e == vecs[v].r2);
                bus.falling = (e == vecs[v].f1) || (e == vecs[v].f2);
                if (bus.rising)  bus.cond = 1'b1;
                if (bus.falling) bus.cond = 1'b0;
                tick();
                if (bus.short_press === 1'b1) begin
                    if (first_s < 0) first_s = e;
                    cnt_s++;
                end
                if (bus.long_press === 1'b1) begin
                    if (first_l < 0) first_l = e;
                    cnt_l++;
                end
                if (bus.double_press === 1'b1) begin
                    if (first_d < 0) first_d = e;
                    cnt_d++;
                end
                if (int'(bus.short_press) + int'(bus.long_press) + int'(bus.double_press) > 1)
                    multi++;
                held_exp = (e >= vecs[v].r1 && e < vecs[v].f1) ||
                           (vecs[v].r2 > 0 && e >= vecs[v].r2 && e < vecs[v].f2);
                if (bus.held !== held_exp) held_bad++;
            end
            bus.rising  = 1'b0;
            bus.falling = 1'b0;
            check({vecs[v].name, "_short_edge"}, first_s, vecs[v].exp_short);
            check({vecs[v].name, "_long_edge"}, first_l, vecs[v].exp_long);
            check({vecs[v].name, "_dbl_edge"}, first_d, vecs[v].exp_dbl);
            check({vecs[v].name, "_short_cnt"}, cnt_s, (vecs[v].exp_short >= 0) ? 1 : 0);
            check({vecs[v].name, "_long_cnt"}, cnt_l, (vecs[v].exp_long >= 0) ? 1 : 0);
            check({vecs[v].name, "_dbl_cnt"}, cnt_d, (vecs[v].exp_dbl >= 0) ? 1 : 0);
            check({vecs[v].name, "_held_errs"}, held_bad, 0);
            check({vecs[v].name, "_mutex"}, multi, 0);
            check({vecs[v].name, "_final_state"}, bus.state, vecs[v].exp_state);
        end

        // Missed falling pulse: cond drops alone while in PRESS1
        do_reset(2);
        bus.rising = 1'b1;
        bus.cond   = 1'b1;
        tick();
        bus.rising = 1'b0;
        tick();
        tick();
        check("missed_fall_press1", bus.state, 1);
        bus.cond = 1'b0;
        tick();
        check("missed_fall_wait", bus.state, 2);
        first_s = -1;
        for (int e = 5; e <= 14; e++) begin
            tick();
            if (bus.short_press === 1'b1 && first_s < 0) first_s = e;
        end
        check("missed_fall_short_edge", first_s, 10);

        // Reset on the fifth edge spent in WAIT aborts the gesture
        do_reset(2);
        bus.rising = 1'b1;
        bus.cond   = 1'b1;
        tick();
        bus.rising = 1'b0;
        tick();
        bus.falling = 1'b1;
        bus.cond    = 1'b0;
        tick();
        bus.falling = 1'b0;
        repeat (4) tick();
        check("wait_before_reset", bus.state, 2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("wait_reset_state", bus.state, 0);
        cnt_s = 0;
        for (int e = 0; e < 12; e++) begin
            tick();
            cnt_s += int'(bus.short_press) + int'(bus.long_press) + int'(bus.double_press);
        end
        check("wait_reset_no_pulse", cnt_s, 0);
        check("wait_reset_idle", bus.state, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/press_classifier.md
Name: press_classifier

Overview:
- Consumes the conditioned button stream (cond, rising, falling) from the input conditioner stage.
- Classifies each user gesture as a short press, long press or double press.
- Emits one-clock pulses to the downstream mode/control logic.
- Fully synchronous to the same clock as the conditioner; no further synchronization or debouncing is performed here.

Parameters:
- LONG_T, 8, number of cycles a press must be held to qualify as long (≥2, ≤2^CW−1).
- DBL_T, 6, number of cycles after a release during which a second press makes a double press (≥2, ≤2^CW−1).
- CW, 4, width of the internal cycle counter.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- cond  input  1  conditioned level from the input conditioner (1 = pressed).
- rising  input  1  one-cycle pulse at a rising edge of cond.
- falling  input  1  one-cycle pulse at a falling edge of cond.
- short_press  output  1  one-cycle pulse: single short press completed.
- long_press  output  1  one-cycle pulse: hold reached LONG_T.
- double_press  output  1  one-cycle pulse: second press released within the window.
- held  output  1  level, high while the FSM is in PRESS1, PRESS2 or LONG.
- state  output  3  current FSM state, for debug.

Behaviour:
- Reset values:
  - reset sampled high at posedge → state=IDLE, cnt=0.
  - short_press, long_press, double_press and held all 0 from the next cycle on.
  - Reset overrides any event in the same cycle, including mid-gesture; no pulse is emitted for an aborted gesture.
- Registering: all outputs are registered. A decision taken at posedge n is visible for exactly the cycle following posedge n. Pulses never exceed 1 cycle.
- State encoding: IDLE=0, PRESS1=1, WAIT=2, PRESS2=3, LONG=4. Codes 5–7 return to IDLE on the next edge.
- Event definition: rising=1 with falling=1 in the same cycle is illegal and is treated as no event.
- IDLE:
  - rising → PRESS1, cnt←0.
  - falling is ignored.
- PRESS1:
  - falling → WAIT, cnt←0.
  - else if cnt==LONG_T−1 → LONG, long_press←1.
  - else cnt←cnt+1.
  - Net timing: rising sampled at edge k with no falling → long_press high after edge k+LONG_T.
- WAIT:
  - rising → PRESS2, cnt←0. Rising takes priority over timeout in the same cycle.
  - else if cnt==DBL_T−1 → IDLE, short_press←1.
  - else cnt←cnt+1.
  - Net timing: falling sampled at edge m → short_press high after edge m+DBL_T if no rising arrives at edges m+1..m+DBL_T.
- PRESS2:
  - falling → IDLE, double_press←1.
  - else if cnt==LONG_T−1 → LONG, long_press←1. The double press is discarded in this case.
  - else cnt←cnt+1.
- LONG:
  - falling → IDLE, with no further pulse.
  - Counter is held; no repeat pulses.
- Counter rules:
  - cnt is CW bits and never wraps, because the compare-to-threshold exits the state first.
  - Parameter values outside the stated range are unsupported.
- cond usage:
  - cond is only a consistency check.
  - In PRESS1/PRESS2/LONG, if cond==0 with no falling seen, the FSM treats it as falling and takes the falling transition, covering a missed pulse.
  - In IDLE/WAIT, cond==1 without rising is ignored.
- Mutual exclusion: at most one of short_press/long_press/double_press is high in any cycle.

Test Plan (LONG_T=8, DBL_T=6, CW=4):
- Reset: hold reset 3 cycles with rising pulsed mid-reset → state=0, all outputs 0, no pulse after reset deasserts.
- Short press: rising at edge 10, falling at edge 13, idle after → short_press high only after edge 19 (13+6); long_press and double_press stay 0; held high after edges 10–12.
- Long press: rising at edge 10, cond held to edge 30 → long_press high only after edge 18; falling at 30 → state=IDLE after edge 30, no other pulse.
- Double press:
  - rising 10, falling 12, rising 15, falling 17 → double_press high after edge 17; short_press never asserted.
  - Repeat with the second rising at edge 18 (=12+6) → double_press still produced (rising wins over timeout).
  - Second rising at edge 19 → short_press after edge 18, then the new gesture starts from IDLE.
- Second-press long: rising 10, falling 12, rising 14, hold through edge 25 → long_press after edge 22, no double_press on the later falling.
- Missed edge / reset mid-gesture:
  - In PRESS1, drop cond with no falling pulse → WAIT entered at that edge.
  - Separately, assert reset at edge 5 of WAIT → IDLE, no short_press ever emitted.
